// File: rtl/wb_mem_slave.sv
// wb_mem_slave: parametrised Wishbone slave memory standing in for the SDRAM
// on the convnet port. One outstanding request, fixed response latency,
// byte-lane writes, error response for out-of-range word addresses, abort
// when the master drops cyc_i during the wait, and optional periodic stall
// injection.

module wb_mem_slave #(
  parameter int DW           = 32,
  parameter int DEPTH        = 128,
  parameter int LATENCY      = 4,
  parameter int STALL_PERIOD = 0
) (
  input  logic            CLK,
  input  logic            rst,
  input  logic            cyc_i,
  input  logic            stb_i,
  input  logic            we_i,
  input  logic [DW/8-1:0] sel_i,
  input  logic [31:0]     addr_i,
  input  logic [DW-1:0]   data_i,
  output logic [DW-1:0]   data_o,
  output logic            sdram_ack,
  output logic            err_o,
  output logic            stall_o
);

  localparam int NB  = DW / 8;
  localparam int IW  = $clog2(DEPTH);
  localparam int SCW = (STALL_PERIOD >= 2) ? $clog2(STALL_PERIOD) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // Countdown start value; WAIT leaves for RESP when the count reaches 1.
  localparam logic [3:0]     LAT_LOAD = 4'(LATENCY - 1);
  localparam logic [SCW-1:0] SC_LAST  = SCW'(STALL_PERIOD - 1);

  logic [1:0]      r_state;
  logic [1:0]      w_next_state;
  logic [3:0]      r_cnt;
  logic [3:0]      w_next_cnt;
  logic            w_enter_resp;

  logic [SCW-1:0]  r_scnt;
  logic            w_inj;
  logic            w_stall;
  logic            w_accept;
  logic            w_in_oor;

  // Request captured at acceptance
  logic            r_we;
  logic [NB-1:0]   r_sel;
  logic [DW-1:0]   r_data;
  logic [IW-1:0]   r_addr;
  logic            r_oor;

  // Request as seen on the edge entering RESP. With a latency of one that
  // edge is the acceptance edge itself, so the live bus inputs are used.
  logic            w_we;
  logic [NB-1:0]   w_sel;
  logic [DW-1:0]   w_wdata;
  logic [IW-1:0]   w_addr;
  logic            w_oor;

  logic            r_ack;
  logic            r_err;
  logic [DW-1:0]   r_rdata;

  logic [DW-1:0]   r_mem [DEPTH];

  assign w_in_oor = |addr_i[31:IW];
  assign w_inj    = (STALL_PERIOD >= 2) && (r_scnt == SC_LAST);
  assign w_stall  = (r_state == S_WAIT) | w_inj;
  // Stall is always high in WAIT, so acceptance can only happen in IDLE/RESP.
  assign w_accept = cyc_i & stb_i & ~w_stall;

  assign w_we    = (LATENCY == 1) ? we_i              : r_we;
  assign w_sel   = (LATENCY == 1) ? sel_i             : r_sel;
  assign w_wdata = (LATENCY == 1) ? data_i            : r_data;
  assign w_addr  = (LATENCY == 1) ? addr_i[IW-1:0]    : r_addr;
  assign w_oor   = (LATENCY == 1) ? w_in_oor          : r_oor;

  assign stall_o   = w_stall;
  assign sdram_ack = r_ack;
  assign err_o     = r_err;
  assign data_o    = r_rdata;

  // Next-state and countdown logic for the request FSM
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_enter_resp = 1'b0;
    case (r_state)
      S_IDLE, S_RESP: begin
        if (w_accept) begin
          w_next_cnt = LAT_LOAD;
          if (LATENCY == 1) begin
            w_next_state = S_RESP;
            w_enter_resp = 1'b1;
          end else begin
            w_next_state = S_WAIT;
          end
        end else begin
          w_next_state = S_IDLE;
          w_next_cnt   = 4'd0;
        end
      end
      S_WAIT: begin
        if (!cyc_i) begin
          // Master abandoned the cycle: drop the request silently.
          w_next_state = S_IDLE;
          w_next_cnt   = 4'd0;
        end else if (r_cnt == 4'd1) begin
          w_next_state = S_RESP;
          w_next_cnt   = 4'd0;
          w_enter_resp = 1'b1;
        end else begin
          w_next_state = S_WAIT;
          w_next_cnt   = r_cnt - 4'd1;
        end
      end
      default: begin
        w_next_state = S_IDLE;
        w_next_cnt   = 4'd0;
      end
    endcase
  end

  // State and countdown registers
  always_ff @(posedge CLK) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  // Capture the request fields at acceptance; the master may change them after
  always_ff @(posedge CLK) begin
    if (rst) begin
      r_we   <= 1'b0;
      r_sel  <= {NB{1'b0}};
      r_data <= {DW{1'b0}};
      r_addr <= {IW{1'b0}};
      r_oor  <= 1'b0;
    end else if (w_accept) begin
      r_we   <= we_i;
      r_sel  <= sel_i;
      r_data <= data_i;
      r_addr <= addr_i[IW-1:0];
      r_oor  <= w_in_oor;
    end else begin
      r_we   <= r_we;
      r_sel  <= r_sel;
      r_data <= r_data;
      r_addr <= r_addr;
      r_oor  <= r_oor;
    end
  end

  // Free-running stall-injection counter, independent of bus activity
  always_ff @(posedge CLK) begin
    if (rst) begin
      r_scnt <= {SCW{1'b0}};
    end else if (STALL_PERIOD >= 2) begin
      r_scnt <= (r_scnt == SC_LAST) ? {SCW{1'b0}} : r_scnt + {{(SCW-1){1'b0}}, 1'b1};
    end else begin
      r_scnt <= {SCW{1'b0}};
    end
  end

  // Registered response: one-cycle ack or err pulse, read data only with ack
  always_ff @(posedge CLK) begin
    if (rst) begin
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= {DW{1'b0}};
    end else if (w_enter_resp) begin
      r_ack   <= ~w_oor;
      r_err   <= w_oor;
      r_rdata <= (!w_oor && !w_we) ? r_mem[w_addr] : {DW{1'b0}};
    end else begin
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= {DW{1'b0}};
    end
  end

  // Storage: byte-lane write on the edge entering RESP; contents survive reset
  always_ff @(posedge CLK) begin
    if (!rst && w_enter_resp && !w_oor && w_we) begin
      for (int b = 0; b < NB; b++) begin
        if (w_sel[b]) begin
          r_mem[w_addr][8*b +: 8] <= w_wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_mem_slave.sv
// Directed bench for wb_mem_slave. Three instances cover the default
// configuration (latency 4), a latency-1 back-to-back configuration and a
// stall-injection configuration (period 5).

module tb_wb_mem_slave;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        rst  [3];
  logic        cyc  [3];
  logic        stb  [3];
  logic        we   [3];
  logic [3:0]  sel  [3];
  logic [31:0] addr [3];
  logic [31:0] wdat [3];
  logic [31:0] rdat [3];
  logic        ack  [3];
  logic        err  [3];
  logic        stall[3];

  logic [31:0] d0, d1, d2;
  logic        a0, a1, a2, e0, e1, e2, s0, s1, s2;

  int n_checks = 0;
  int n_err    = 0;

  wb_mem_slave #(.DW(32), .DEPTH(128), .LATENCY(4), .STALL_PERIOD(0)) u_dut0 (
    .CLK(CLK), .rst(rst[0]), .cyc_i(cyc[0]), .stb_i(stb[0]), .we_i(we[0]),
    .sel_i(sel[0]), .addr_i(addr[0]), .data_i(wdat[0]), .data_o(d0),
    .sdram_ack(a0), .err_o(e0), .stall_o(s0));

  wb_mem_slave #(.DW(32), .DEPTH(128), .LATENCY(1), .STALL_PERIOD(0)) u_dut1 (
    .CLK(CLK), .rst(rst[1]), .cyc_i(cyc[1]), .stb_i(stb[1]), .we_i(we[1]),
    .sel_i(sel[1]), .addr_i(addr[1]), .data_i(wdat[1]), .data_o(d1),
    .sdram_ack(a1), .err_o(e1), .stall_o(s1));

  wb_mem_slave #(.DW(32), .DEPTH(128), .LATENCY(4), .STALL_PERIOD(5)) u_dut2 (
    .CLK(CLK), .rst(rst[2]), .cyc_i(cyc[2]), .stb_i(stb[2]), .we_i(we[2]),
    .sel_i(sel[2]), .addr_i(addr[2]), .data_i(wdat[2]), .data_o(d2),
    .sdram_ack(a2), .err_o(e2), .stall_o(s2));

  always_comb begin
    rdat[0] = d0; rdat[1] = d1; rdat[2] = d2;
    ack[0]  = a0; ack[1]  = a1; ack[2]  = a2;
    err[0]  = e0; err[1]  = e1; err[2]  = e2;
    stall[0] = s0; stall[1] = s1; stall[2] = s2;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Starts and ends just after a falling edge. waits = edges the request was
  // held off by stall; lat = edges from acceptance (inclusive) to response;
  // nst = cycles with stall_o high while waiting for the response.
  task automatic xact(input int k, input logic w, input logic [3:0] s,
                      input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic ra, output logic re,
                      output int lat, output int waits, output int nst);
    bit acc;
    bit done;
    rd = 32'h0; ra = 1'b0; re = 1'b0; lat = 0; waits = 0; nst = 0;
    acc = 1'b0; done = 1'b0;
    cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; sel[k] = s; addr[k] = a; wdat[k] = d;
    for (int i = 0; i < 20 && !acc; i++) begin
      if (!stall[k]) acc = 1'b1;
      else waits++;
      @(negedge CLK);
    end
    stb[k] = 1'b0;
    if (!acc) begin
      check("accept_timeout", 32'd0, 32'd1);
    end else begin
      for (int n = 1; n <= 20 && !done; n++) begin
        if (ack[k] || err[k]) begin
          done = 1'b1; rd = rdat[k]; ra = ack[k]; re = err[k]; lat = n;
        end else begin
          if (stall[k]) nst++;
          @(negedge CLK);
        end
      end
      if (!done) check("resp_timeout", 32'd0, 32'd1);
    end
    cyc[k] = 1'b0; we[k] = 1'b0;
  endtask

  // Counts response pulses (ack or err) over ncyc cycles
  task automatic watch(input int k, input int ncyc, output int nresp);
    nresp = 0;
    for (int i = 0; i < ncyc; i++) begin
      if (ack[k] || err[k]) nresp++;
      @(negedge CLK);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        ra, re;
    int          lat, waits, nst, nresp;
    logic [31:0] pat;
    logic [31:0] b2b_data [4];

    b2b_data[0] = 32'h0000_1000; b2b_data[1] = 32'h1111_2001;
    b2b_data[2] = 32'h2222_3002; b2b_data[3] = 32'h3333_4003;

    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0;
      sel[k] = 4'h0; addr[k] = 32'h0; wdat[k] = 32'h0;
    end
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;

    // Reset state
    check("rst_ack",   {31'd0, ack[0]},   32'd0);
    check("rst_err",   {31'd0, err[0]},   32'd0);
    check("rst_data",  rdat[0],           32'd0);
    check("rst_stall", {31'd0, stall[0]}, 32'd0);

    // Injected stall pattern while idle: counter is 0 right after reset
    pat = 32'h0;
    for (int i = 0; i < 15; i++) begin
      pat[i] = stall[2];
      @(negedge CLK);
    end
    check("inj_pattern", pat, 32'h0000_4210);

    // Full-word write, latency and stall during WAIT
    xact(0, 1'b1, 4'hF, 32'd5, 32'hDEAD_BEEF, rd, ra, re, lat, waits, nst);
    check("wr5_lat",   lat,          32'd4);
    check("wr5_ack",   {31'd0, ra},  32'd1);
    check("wr5_err",   {31'd0, re},  32'd0);
    check("wr5_stall", nst,          32'd3);
    @(negedge CLK);
    check("wr5_ack_1cyc", {31'd0, ack[0]}, 32'd0);
    xact(0, 1'b0, 4'hF, 32'd5, 32'h0, rd, ra, re, lat, waits, nst);
    check("rd5_data", rd, 32'hDEAD_BEEF);
    check("rd5_ack",  {31'd0, ra}, 32'd1);
    @(negedge CLK);
    check("rd5_data_after", rdat[0], 32'd0);

    // Byte lanes
    xact(0, 1'b1, 4'hF, 32'd7, 32'h1122_3344, rd, ra, re, lat, waits, nst);
    xact(0, 1'b1, 4'b0101, 32'd7, 32'hAABB_CCDD, rd, ra, re, lat, waits, nst);
    check("wr7_sel5_ack", {31'd0, ra}, 32'd1);
    xact(0, 1'b0, 4'hF, 32'd7, 32'h0, rd, ra, re, lat, waits, nst);
    check("rd7_lanes", rd, 32'h11BB_33DD);

    // Out of range
    xact(0, 1'b1, 4'hF, 32'd0, 32'h1234_5678, rd, ra, re, lat, waits, nst);
    xact(0, 1'b0, 4'hF, 32'd128, 32'h0, rd, ra, re, lat, waits, nst);
    check("oor_rd_err",  {31'd0, re}, 32'd1);
    check("oor_rd_ack",  {31'd0, ra}, 32'd0);
    check("oor_rd_data", rd,          32'd0);
    xact(0, 1'b1, 4'hF, 32'h200, 32'hFFFF_FFFF, rd, ra, re, lat, waits, nst);
    check("oor_wr_err", {31'd0, re}, 32'd1);
    xact(0, 1'b0, 4'hF, 32'd0, 32'h0, rd, ra, re, lat, waits, nst);
    check("oor_addr0_kept", rd, 32'h1234_5678);

    // Abort: cyc_i dropped two cycles after acceptance
    xact(0, 1'b1, 4'hF, 32'd9, 32'hCAFE_0009, rd, ra, re, lat, waits, nst);
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; sel[0] = 4'hF;
    addr[0] = 32'd9; wdat[0] = 32'h0000_0055;
    @(negedge CLK);
    stb[0] = 1'b0;
    @(negedge CLK);
    cyc[0] = 1'b0; we[0] = 1'b0;
    watch(0, 6, nresp);
    check("abort_no_resp", nresp, 32'd0);
    check("abort_idle_stall", {31'd0, stall[0]}, 32'd0);
    xact(0, 1'b0, 4'hF, 32'd9, 32'h0, rd, ra, re, lat, waits, nst);
    check("abort_addr9_kept", rd, 32'hCAFE_0009);

    // Latency 1: fill, then four back-to-back reads
    for (int i = 0; i < 4; i++) begin
      xact(1, 1'b1, 4'hF, i, b2b_data[i], rd, ra, re, lat, waits, nst);
      if (i == 0) check("l1_wr_lat", lat, 32'd1);
    end
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; sel[1] = 4'hF; addr[1] = 32'd0;
    for (int i = 0; i < 4; i++) begin
      check("b2b_stall", {31'd0, stall[1]}, 32'd0);
      @(negedge CLK);
      check("b2b_ack",  {31'd0, ack[1]}, 32'd1);
      check("b2b_data", rdat[1], b2b_data[i]);
      addr[1] = i + 1;
    end
    cyc[1] = 1'b0; stb[1] = 1'b0;
    @(negedge CLK);
    check("b2b_end_ack", {31'd0, ack[1]}, 32'd0);

    // Request raised while injected stall is high is held off one cycle
    for (int i = 0; i < 10 && !stall[2]; i++) @(negedge CLK);
    check("inj_found", {31'd0, stall[2]}, 32'd1);
    xact(2, 1'b1, 4'hF, 32'd3, 32'h3333_3333, rd, ra, re, lat, waits, nst);
    check("inj_wait", waits, 32'd1);
    check("inj_lat",  lat,   32'd4);
    check("inj_ack",  {31'd0, ra}, 32'd1);

    // Reset during WAIT discards the request
    cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; sel[2] = 4'hF;
    addr[2] = 32'd3; wdat[2] = 32'h0000_00A5;
    for (int i = 0; i < 10 && stall[2]; i++) @(negedge CLK);
    @(negedge CLK);
    stb[2] = 1'b0; rst[2] = 1'b1;
    @(negedge CLK);
    rst[2] = 1'b0; cyc[2] = 1'b0; we[2] = 1'b0;
    check("rstwait_stall", {31'd0, stall[2]}, 32'd0);
    watch(2, 6, nresp);
    check("rstwait_no_resp", nresp, 32'd0);
    xact(2, 1'b0, 4'hF, 32'd3, 32'h0, rd, ra, re, lat, waits, nst);
    check("rstwait_addr3_kept", rd, 32'h3333_3333);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_mem_slave.md
# wb_mem_slave

Parametrised, synthesizable Wishbone slave memory that succeeds the fixed 120-word, 4-cycle pseudo SDRAM used in the ConvNet bench. It adds configurable width, depth and latency, plus byte-lane writes, single-cycle ack pulses, out-of-range error responses, bus-abort handling and periodic stall injection. It sits on the `convnet` SDRAM Wishbone port, both in simulation and as an on-chip stand-in for the SDRAM controller.

## Interface
- `DW`, 32: data width; multiple of 8; `DW/8` byte lanes.
- `DEPTH`, 128: words of storage; power of two; `IW = log2(DEPTH)`.
- `LATENCY`, 4: cycles from acceptance edge to response; range 1..15.
- `STALL_PERIOD`, 0: 0 disables injection; N ≥ 2 forces `stall_o` high one cycle in every N.

- `CLK`  in  1: clock; all logic on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `cyc_i`  in  1: bus cycle valid.
- `stb_i`  in  1: request strobe.
- `we_i`  in  1: 1 = write, 0 = read.
- `sel_i`  in  DW/8: byte-lane enables for writes.
- `addr_i`  in  32: word address.
- `data_i`  in  DW: write data.
- `data_o`  out  DW: read data; valid only while `sdram_ack` is high, otherwise 0.
- `sdram_ack`  out  1: one-cycle successful-response pulse.
- `err_o`  out  1: one-cycle error-response pulse.
- `stall_o`  out  1: slave cannot accept a request this cycle.

## Operation
- Acceptance: a request is accepted at a rising edge when `cyc_i & stb_i & ~stall_o`.
  - At acceptance the block registers `we_i`, `sel_i`, `data_i`, `addr_i[IW-1:0]` and the range flag (`addr_i[31:IW] != 0`).
  - The master may change these inputs afterwards.
- Only one request is outstanding at a time.
- FSM states:
  - IDLE: on acceptance go to WAIT, or to RESP when `LATENCY == 1`. Load the countdown with `LATENCY-1`.
  - WAIT: decrement the countdown each cycle; go to RESP when it reaches 1. If `cyc_i` is 0, go to IDLE with no response and no write.
  - RESP: lasts exactly one cycle. Go to WAIT/RESP if a new request is accepted this cycle, otherwise to IDLE.
- Response, on the edge entering RESP:
  - In-range write: byte lane b is written only if `sel_i[b]` was set. `sel=0` writes nothing but still acks.
  - In-range read: `data_o` is loaded with the stored word. A read of a never-written word returns X in simulation; no reset of contents.
  - Out-of-range request: `err_o` in place of `sdram_ack`, no write, `data_o` = 0.
- `stall_o` = (state == WAIT) | injected stall. It is low in IDLE and RESP, so back-to-back requests are allowed.
- Stall injection:
  - A free-running counter counts 0..STALL_PERIOD-1 and wraps.
  - The injected stall is high when the counter equals STALL_PERIOD-1.
  - The counter runs regardless of bus state.
- If `cyc_i` drops during RESP, the response still completes; the write was already committed.
- `sdram_ack` and `err_o` are never high together and never high outside RESP.

## Timing
- Reset: after the reset edge, state = IDLE, `sdram_ack` = 0, `err_o` = 0, `data_o` = 0, `stall_o` = 0, stall counter = 0. Memory contents are preserved.
- Reset asserted mid-request discards the request: no write, no response.
- Latency: with acceptance at edge t, the response is high during the cycle after edge t+LATENCY-1. For example, LATENCY=4 gives a response 4 edges after acceptance.
- Throughput: one request per LATENCY cycles (back-to-back via RESP).
- A request arriving while `stall_o` = 1 is not accepted. The master must hold `stb_i` high; acceptance occurs on the first edge with `stall_o` = 0.
- Injection applies in every state. In RESP it blocks back-to-back acceptance for that cycle.
- All outputs are registered except `stall_o`, which is combinational from the state and the stall counter.

## Test plan
- Reset with DW=32, DEPTH=128, LATENCY=4, STALL_PERIOD=0:
  - Hold `rst` for 2 cycles → all outputs 0.
  - Write 0xDEADBEEF to addr 5 with sel=4'hF → `sdram_ack` high exactly 4 edges after acceptance, for 1 cycle.
  - `stall_o` high during the 3 WAIT cycles.
- Byte lanes: write 0x11223344 to addr 7 (sel=F), then write 0xAABBCCDD with sel=4'b0101 → a later read of addr 7 returns 0x11BB33DD.
- Back-to-back with LATENCY=1: hold `cyc_i`/`stb_i` high with 4 reads of addrs 0..3 → 4 consecutive ack cycles with matching data and `stall_o` low throughout.
- Out of range: read addr 128 → `err_o` pulse, `sdram_ack` 0, `data_o` 0. Write addr 0x200 → `err_o`, and addr 0 is unchanged on readback.
- Abort: write 0x55 to addr 9, drop `cyc_i` 2 cycles after acceptance → no ack, no err. A readback of addr 9 returns the prior value.
- Stall injection, STALL_PERIOD=5: request asserted while injected stall is high → acceptance delayed by exactly 1 cycle. Also `stall_o` pulses every 5 cycles while idle, and `rst` mid-WAIT gives no response.
